// File: rtl/spike_pkg.sv
// -----------------------------------------------------------------------------
// spike_pkg
// Shared types and constants for the spike rate decoder.
//   state_e        : decoder FSM states (IDLE, COUNT)
//   V_W            : membrane sample width
//   RATE_W         : width of the per-window spike count / rate output
//   ISI_W          : width of the inter-spike interval counter / output
//   THRESH_DEFAULT : default membrane level that counts as a spike
// -----------------------------------------------------------------------------
package spike_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int V_W    = 8;
    localparam int RATE_W = 8;
    localparam int ISI_W  = 16;

    localparam logic [V_W-1:0] THRESH_DEFAULT = 8'd200;

endpackage

// File: rtl/spike_rate_decoder_edge.sv
// -----------------------------------------------------------------------------
// spike_edge_detect
// Rising threshold-crossing detector on the membrane value.
// Ports:
//   clk    in  : clock, rising edge
//   rst_n  in  : synchronous active-low reset
//   clr    in  : clears the history (decoder not running)
//   v_mem  in  : membrane sample
//   thresh in  : spike threshold
//   spike  out : registered one-cycle pulse, the cycle after a crossing sample
// -----------------------------------------------------------------------------
module spike_edge_detect
    import spike_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [V_W-1:0] v_mem,
    input  logic [V_W-1:0] thresh,
    output logic           spike
);

    logic [V_W-1:0] prev_v_q, prev_v_d;
    logic           primed_q, primed_d;
    logic           spike_q,  spike_d;

    // prev_v restarts at 0 after a clear, so the first sample after a clear
    // only primes the history; otherwise a membrane already sitting above
    // threshold would be reported as a fresh crossing.
    always_comb begin
        prev_v_d = '0;
        primed_d = 1'b0;
        spike_d  = 1'b0;
        if (!clr) begin
            prev_v_d = v_mem;
            primed_d = 1'b1;
            spike_d  = primed_q && (v_mem >= thresh) && (prev_v_q < thresh);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_v_q <= '0;
            primed_q <= 1'b0;
            spike_q  <= 1'b0;
        end else begin
            prev_v_q <= prev_v_d;
            primed_q <= primed_d;
            spike_q  <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Turns a QIF membrane trace into spike pulses, a windowed spike rate and an
// inter-spike interval.
// Parameters:
//   WINDOW : rate window length in clk cycles (2 .. 2^24-1)
//   THRESH : membrane level that counts as a spike
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : synchronous active-low reset
//   ena        in  : decoder enable; dropping it abandons the current window
//   v_mem      in  : unsigned membrane value
//   spike      out : one-cycle pulse per rising threshold crossing
//   rate       out : spike count of the last completed window (saturating)
//   rate_valid out : one-cycle pulse when rate is loaded
//   overflow   out : last completed window lost spikes to saturation
//   isi        out : cycles between the last two spikes (saturating)
//   isi_valid  out : one-cycle pulse when isi is loaded
// -----------------------------------------------------------------------------
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter logic [23:0]    WINDOW = 24'd10_000_000,
    parameter logic [V_W-1:0] THRESH = THRESH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [V_W-1:0]    v_mem,
    output logic              spike,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic              overflow,
    output logic [ISI_W-1:0]  isi,
    output logic              isi_valid
);

    state_e              state_q, state_d;
    logic [23:0]         win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0]   spike_cnt_q, spike_cnt_d;
    logic                sat_q, sat_d;
    logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
    logic                armed_q, armed_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic                overflow_q, overflow_d;
    logic                rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]    isi_q, isi_d;
    logic                isi_valid_q, isi_valid_d;

    logic                run;
    logic                win_close;
    logic [RATE_W-1:0]   spike_cnt_sum;
    logic                sat_sum;

    function automatic logic [RATE_W-1:0] sat_inc_rate(input logic [RATE_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    function automatic logic [ISI_W-1:0] sat_inc_isi(input logic [ISI_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // A cycle in COUNT with ena already low behaves as IDLE, so no pulse
    // can escape after the enable drops.
    assign run = (state_q == COUNT) && ena;

    spike_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!run),
        .v_mem  (v_mem),
        .thresh (THRESH),
        .spike  (spike)
    );

    // The spike pulse visible in the closing cycle still belongs to the
    // closing window, hence the sum is formed before the close decision.
    // Overflow means a spike was dropped, i.e. one arrived at a full count.
    assign win_close     = (win_cnt_q == WINDOW - 24'd1);
    assign spike_cnt_sum = spike ? sat_inc_rate(spike_cnt_q) : spike_cnt_q;
    assign sat_sum       = sat_q | (spike & (&spike_cnt_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena)  state_d = COUNT;
            COUNT:   if (!ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        win_cnt_d    = '0;
        spike_cnt_d  = '0;
        sat_d        = 1'b0;
        isi_cnt_d    = '0;
        armed_d      = 1'b0;
        rate_d       = rate_q;
        overflow_d   = overflow_q;
        rate_valid_d = 1'b0;
        isi_d        = isi_q;
        isi_valid_d  = 1'b0;

        if (run) begin
            if (win_close) begin
                rate_d       = spike_cnt_sum;
                overflow_d   = sat_sum;
                rate_valid_d = 1'b1;
            end else begin
                win_cnt_d   = win_cnt_q + 24'd1;
                spike_cnt_d = spike_cnt_sum;
                sat_d       = sat_sum;
            end

            // The first spike only arms the interval counter.
            if (spike) begin
                if (armed_q) begin
                    isi_d       = isi_cnt_q;
                    isi_valid_d = 1'b1;
                end
                armed_d   = 1'b1;
                isi_cnt_d = {{(ISI_W-1){1'b0}}, 1'b1};
            end else begin
                armed_d   = armed_q;
                isi_cnt_d = armed_q ? sat_inc_isi(isi_cnt_q) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            spike_cnt_q  <= '0;
            sat_q        <= 1'b0;
            isi_cnt_q    <= '0;
            armed_q      <= 1'b0;
            rate_q       <= '0;
            overflow_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            sat_q        <= sat_d;
            isi_cnt_q    <= isi_cnt_d;
            armed_q      <= armed_d;
            rate_q       <= rate_d;
            overflow_q   <= overflow_d;
            rate_valid_q <= rate_valid_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign rate       = rate_q;
    assign overflow   = overflow_q;
    assign rate_valid = rate_valid_q;
    assign isi        = isi_q;
    assign isi_valid  = isi_valid_q;

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WINDOW, default 24'd10_000_000, giving the rate-window length in clk cycles (legal range 2..2^24-1).
REQ-002 SHALL have parameter THRESH, default 8'd200, giving the membrane level that counts as a spike.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: decoder enable, active high.
REQ-006 SHALL have port v_mem, input, 8 bits: unsigned membrane value from the QIF neuron.
REQ-007 SHALL have port spike, output, 1 bit: one-cycle pulse per detected spike.
REQ-008 SHALL have port rate, output, 8 bits: spike count of the last completed window, saturating.
REQ-009 SHALL have port rate_valid, output, 1 bit: one-cycle pulse when rate updates.
REQ-010 SHALL have port overflow, output, 1 bit: set when the last completed window saturated.
REQ-011 SHALL have port isi, output, 16 bits: inter-spike interval in cycles, saturating.
REQ-012 SHALL have port isi_valid, output, 1 bit: one-cycle pulse when isi updates.

Function
REQ-013 SHALL register v_mem into prev_v every cycle while in COUNT.
REQ-014 SHALL assert spike for one cycle, in the cycle after the sample, when v_mem >= THRESH and prev_v < THRESH (a rising crossing only); a sustained level SHALL NOT retrigger.
REQ-015 SHALL implement states IDLE and COUNT: IDLE->COUNT when ena=1; COUNT->IDLE when ena=0.
REQ-016 In IDLE SHALL clear the window counter, spike counter, ISI counter, first-spike flag and prev_v (to 0); rate, overflow and isi SHALL hold their values; all pulses SHALL be 0.
REQ-017 In COUNT SHALL increment the window counter each cycle, from 0 to WINDOW-1, then wrap to 0.
REQ-018 On the cycle where the window counter equals WINDOW-1, SHALL load rate with the window spike count and pulse rate_valid, and SHALL clear the spike counter.
REQ-019 SHALL saturate the spike count at 255; overflow SHALL load 1 at window close if saturation occurred in that window, else 0.
REQ-020 A spike pulse coinciding with the window-close cycle SHALL be counted in the closing window.
REQ-021 SHALL count cycles since the previous spike in a 16-bit counter saturating at 16'hFFFF.
REQ-022 On each spike after the first since entering COUNT, SHALL load isi with the counter value, pulse isi_valid and restart the count at 1 on the next cycle.
REQ-023 The first spike after reset or after entering COUNT SHALL NOT pulse isi_valid; it only arms the ISI counter.
REQ-024 Spike detection latency SHALL be 1 cycle from the v_mem sample; rate, rate_valid, isi and isi_valid SHALL all be registered outputs.

Reset
REQ-025 With rst_n=0 at a clock edge, SHALL enter IDLE and set spike, rate, rate_valid, overflow, isi, isi_valid, prev_v and all counters to 0.
REQ-026 A reset asserted mid-window SHALL discard the partial count; no rate_valid SHALL be emitted for that window.

Structure
REQ-027 Package spike_pkg SHALL hold the state enum (IDLE, COUNT), RATE_W=8, ISI_W=16 and the default THRESH.
REQ-028 Threshold-crossing detection SHALL be a sub-module, spike_edge_detect (inputs clk, rst_n, clr, v_mem, thresh; output spike).
REQ-029 Total RTL SHALL fit in 120-400 lines, with no latches and no asynchronous logic.

Verification (WINDOW=16, THRESH=200)
REQ-030 Reset: hold rst_n=0 for 3 cycles with v_mem=255 -> all outputs 0; no spike follows release until v_mem first drops below 200 and then rises again.
REQ-031 Rate: ena=1, v_mem toggles 0/255 every 4 cycles -> 2 spikes per window; rate=2, rate_valid pulses every 16 cycles, overflow=0.
REQ-032 ISI: crossings at cycles 10, 17 and 30 -> no isi_valid at 10; isi=7 at the second spike and isi=13 at the third.
REQ-033 Boundary: a crossing whose spike pulse lands on window-close cycle 15 -> counted in the closing window's rate; the next window starts from 0.
REQ-034 Saturation: WINDOW=1024, v_mem toggles every cycle -> rate=255, overflow=1; ISI with no spike for 70000 cycles -> isi=16'hFFFF.
REQ-035 Enable drop: ena=0 mid-window -> no rate_valid; rate holds its value; re-enabling starts a fresh window, and the next spike does not pulse isi_valid.
